// File: rtl/framebuffer_mono_dp_if.sv
// -----------------------------------------------------------------------------
// framebuffer_mono_dp_if
//
// Bundle of the framebuffer's write, scan-read, clear and bank-control signals.
//   master : drawing/scan side (drives requests, receives read data and status)
//   slave  : the framebuffer itself
//
// Signals
//   we, wx, wy, wdata, wmask   masked byte write request (wx[2:0] ignored)
//   re, rx, ry                 scan read request (rx[2:0] ignored)
//   rdata, rvalid              read data, 1 cycle after re
//   clear_req, clear_val       whole-buffer fill request and fill byte
//   swap                       front/back swap request (double-buffer builds)
//   busy                       clear in progress
//   front                      currently displayed bank
// -----------------------------------------------------------------------------
interface framebuffer_mono_dp_if;
    logic       we;
    logic [7:0] wx;
    logic [7:0] wy;
    logic [7:0] wdata;
    logic [7:0] wmask;
    logic       re;
    logic [7:0] rx;
    logic [7:0] ry;
    logic [7:0] rdata;
    logic       rvalid;
    logic       clear_req;
    logic [7:0] clear_val;
    logic       swap;
    logic       busy;
    logic       front;

    modport master (
        output we, wx, wy, wdata, wmask,
        output re, rx, ry,
        output clear_req, clear_val, swap,
        input  rdata, rvalid, busy, front
    );

    modport slave (
        input  we, wx, wy, wdata, wmask,
        input  re, rx, ry,
        input  clear_req, clear_val, swap,
        output rdata, rvalid, busy, front
    );
endinterface

// File: rtl/framebuffer_mono_dp.sv
// -----------------------------------------------------------------------------
// framebuffer_mono_dp
//
// Monochrome framebuffer, 1 bit per pixel, 8 horizontally adjacent pixels per
// byte (bit 7 = leftmost). Independent masked-write port (2-stage
// read-modify-write with forwarding), 1-cycle scan-read port, and a clear
// engine that fills the buffer one byte per cycle.
//
// Parameters
//   H_PIXELS  horizontal resolution (multiple of 8)
//   V_PIXELS  vertical resolution
//
// Ports
//   clk   clock
//   rst   synchronous active-high reset
//   bus   framebuffer_mono_dp_if.slave (write, read, clear, swap, status)
//
// Build option
//   FRAMEBUFFER_DOUBLE_BUFFER_EN  two banks; writes/clears go to the back bank,
//                                 reads come from the front bank, swap toggles
//                                 front. Undefined: single bank, front = 0.
// -----------------------------------------------------------------------------
module framebuffer_mono_dp #(
    parameter int H_PIXELS = 128,
    parameter int V_PIXELS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    framebuffer_mono_dp_if.slave  bus
);

    localparam int HB    = H_PIXELS / 8;
    localparam int DEPTH = HB * V_PIXELS;
    localparam int AW    = $clog2(DEPTH);
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
    localparam int NBANKS = 2;
`else
    localparam int NBANKS = 1;
`endif
    localparam int RAM_DEPTH = NBANKS * DEPTH;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Address helpers
    // -------------------------------------------------------------------------
    function automatic logic in_range(input logic [7:0] x, input logic [7:0] y);
        return (32'(x) < 32'(H_PIXELS)) && (32'(y) < 32'(V_PIXELS));
    endfunction

    function automatic logic [AW-1:0] byte_addr(input logic [7:0] x, input logic [7:0] y);
        logic [31:0] a;
        a = 32'(y) * 32'(HB) + 32'(x[7:3]);
        return AW'(a);
    endfunction

    function automatic logic [RAM_AW-1:0] ram_index(input logic bank, input logic [AW-1:0] a);
        return RAM_AW'(32'(bank) * 32'(DEPTH) + 32'(a));
    endfunction

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [7:0]        r_ram [0:RAM_DEPTH-1];

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_busy;
    logic              w_clr_we;
    logic              w_clr_start;
    logic [AW-1:0]     r_clr_cnt;
    logic [7:0]        r_clr_val;
    logic              r_clr_bank;
    logic              w_clr_last;

    logic              w_front;
    logic              w_back;

    logic              w_w_in_range;
    logic              w_accept;
    logic [RAM_AW-1:0] w_w_idx;

    logic              r_s1_valid;
    logic [RAM_AW-1:0] r_s1_idx;
    logic [7:0]        r_s1_data;
    logic [7:0]        r_s1_mask;
    logic              r_s1_fwd;
    logic [7:0]        r_s1_fwd_byte;
    logic [7:0]        r_old;
    logic [7:0]        w_s1_old;
    logic [7:0]        w_s1_merged;

    logic              w_ram_we;
    logic [RAM_AW-1:0] w_ram_widx;
    logic [7:0]        w_ram_wdata;

    logic              w_r_in_range;
    logic [RAM_AW-1:0] w_r_idx;
    logic [7:0]        r_rdata;
    logic              r_rvalid;

    // -------------------------------------------------------------------------
    // Clear FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge value of every other register, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_clr_last  = (r_clr_cnt == AW'(DEPTH - 1));
    assign w_clr_start = bus.clear_req && (r_state == ST_IDLE);

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_clr_we    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.clear_req) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_busy   = 1'b1;
                w_clr_we = 1'b1;
                if (w_clr_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Fill byte and target bank are captured at acceptance; a later change of
    // clear_val or a swap request cannot alter a clear already running.
    always_ff @(posedge clk) begin
        if (w_clr_start) begin
            r_clr_cnt  <= '0;
            r_clr_val  <= bus.clear_val;
            r_clr_bank <= w_back;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Bank selection
    // -------------------------------------------------------------------------
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
    logic r_front;
    logic r_swap_pend;
    logic w_swap_ok;

    // A swap waits until no clear runs, the write pipeline is empty and no new
    // write or clear is starting, so no byte lands in the bank being displayed.
    assign w_swap_ok = !w_busy && !r_s1_valid && !w_accept && !w_clr_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_front     <= 1'b0;
            r_swap_pend <= 1'b0;
        end else if ((bus.swap || r_swap_pend) && w_swap_ok) begin
            r_front     <= ~r_front;
            r_swap_pend <= 1'b0;
        end else if (bus.swap) begin
            r_swap_pend <= 1'b1;
        end
    end

    assign w_front = r_front;
    assign w_back  = ~r_front;

    logic w_unused_bits;
    assign w_unused_bits = ^{bus.wx[2:0], bus.rx[2:0]};
`else
    assign w_front = 1'b0;
    assign w_back  = 1'b0;

    logic w_unused_bits;
    assign w_unused_bits = ^{bus.wx[2:0], bus.rx[2:0], bus.swap};
`endif

    // -------------------------------------------------------------------------
    // Write pipeline: S0 accepts and reads old byte, S1 merges and commits
    // -------------------------------------------------------------------------
    assign w_w_in_range = in_range(bus.wx, bus.wy);
    assign w_w_idx      = ram_index(w_back, w_w_in_range ? byte_addr(bus.wx, bus.wy) : '0);
    assign w_accept     = bus.we && !w_busy && !bus.clear_req && w_w_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
        end
    end

    // The RAM read in S0 cannot see the byte S1 is committing in the same
    // cycle, so a same-address follow-on write takes S1's merged byte instead.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_idx      <= w_w_idx;
            r_s1_data     <= bus.wdata;
            r_s1_mask     <= bus.wmask;
            r_s1_fwd      <= r_s1_valid && (r_s1_idx == w_w_idx);
            r_s1_fwd_byte <= w_s1_merged;
        end
    end

    assign w_s1_old    = r_s1_fwd ? r_s1_fwd_byte : r_old;
    assign w_s1_merged = (w_s1_old & ~r_s1_mask) | (r_s1_data & r_s1_mask);

    // -------------------------------------------------------------------------
    // RAM write port: clear engine has priority (S1 is always empty during a
    // clear because writes are refused from the accepting cycle onward)
    // -------------------------------------------------------------------------
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_widx  = r_s1_idx;
        w_ram_wdata = w_s1_merged;
        if (w_clr_we) begin
            w_ram_we    = 1'b1;
            w_ram_widx  = ram_index(r_clr_bank, r_clr_cnt);
            w_ram_wdata = r_clr_val;
        end else if (r_s1_valid) begin
            w_ram_we = 1'b1;
        end
    end

    // NOTE: the storage array has no reset; clearing it is the job of the clear
    // engine, and a reset branch here would prevent block-RAM inference.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_widx] <= w_ram_wdata;
        end
        r_old <= r_ram[w_w_idx];
    end

    // -------------------------------------------------------------------------
    // Scan read port (read-first: a commit in the same cycle is not seen)
    // -------------------------------------------------------------------------
    assign w_r_in_range = in_range(bus.rx, bus.ry);
    assign w_r_idx      = ram_index(w_front, w_r_in_range ? byte_addr(bus.rx, bus.ry) : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 8'h00;
        end else begin
            r_rvalid <= bus.re;
            if (bus.re) begin
                r_rdata <= w_r_in_range ? r_ram[w_r_idx] : 8'h00;
            end
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign bus.busy   = w_busy;
    assign bus.front  = w_front;

endmodule

// File: tb/tb_framebuffer_mono_dp.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_mono_dp
//
// Directed and randomized checks of framebuffer_mono_dp against a byte-array
// reference model. Build with FRAMEBUFFER_DOUBLE_BUFFER_EN to exercise the
// double-buffered variant.
// -----------------------------------------------------------------------------
module tb_framebuffer_mono_dp;

    localparam int H     = 128;
    localparam int V     = 64;
    localparam int DEPTH = (H / 8) * V;

    logic clk;
    logic rst;

    framebuffer_mono_dp_if bus ();

    framebuffer_mono_dp #(
        .H_PIXELS (H),
        .V_PIXELS (V)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [7:0] mem [0:2*DEPTH-1];
    logic       front_m;
    int         n_checks;
    int         n_fail;

    typedef struct {
        int         t;
        int         idx;
        logic [7:0] d;
        logic [7:0] m;
    } pw_t;

    pw_t        pq[$];
    pw_t        pw;
    bit         prev_re;
    logic [7:0] prev_exp;
    int         rx_i, ry_i, wx_i, wy_i;
    logic [7:0] wd, wm;

    function automatic int wbank();
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
        return front_m ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    function automatic int rbank();
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
        return front_m ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic bit in_rng(input int x, input int y);
        return (x < H) && (y < V);
    endfunction

    function automatic int idx_of(input int bank, input int x, input int y);
        return bank * DEPTH + y * (H / 8) + x / 8;
    endfunction

    function automatic logic [7:0] model_rd(input int x, input int y);
        if (!in_rng(x, y)) return 8'h00;
        return mem[idx_of(rbank(), x, y)];
    endfunction

    task automatic model_wr(input int x, input int y, input logic [7:0] d, input logic [7:0] m);
        int i;
        if (in_rng(x, y)) begin
            i = idx_of(wbank(), x, y);
            mem[i] = (mem[i] & ~m) | (d & m);
        end
    endtask

    // -------------------------------------------------------------------------
    // Bench helpers
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int x, input int y, input string tag);
        logic [7:0] exp;
        exp = model_rd(x, y);
        bus.re = 1'b1;
        bus.rx = 8'(x);
        bus.ry = 8'(y);
        tick();
        bus.re = 1'b0;
        check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
        check(tag, 32'(bus.rdata), 32'(exp));
    endtask

    task automatic do_write(input int x, input int y, input logic [7:0] d, input logic [7:0] m);
        bus.we    = 1'b1;
        bus.wx    = 8'(x);
        bus.wy    = 8'(y);
        bus.wdata = d;
        bus.wmask = m;
        tick();
        bus.we = 1'b0;
        model_wr(x, y, d, m);
    endtask

    task automatic do_swap();
        bus.swap = 1'b1;
        tick();
        bus.swap = 1'b0;
        front_m = ~front_m;
        check("front_after_swap", 32'(bus.front), 32'(front_m));
    endtask

    // Make the bank last written visible on the read port.
    task automatic show_back();
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
        do_swap();
`endif
    endtask

    // Clear with optional write attempt during the fill, simultaneous write on
    // the request cycle, and swap request during the fill.
    task automatic do_clear(input logic [7:0] v, input int wr_at, input bit with_we, input int swap_at);
        int   cnt;
        int   wb;
        logic f0;
        bit   fchg;
        wb            = wbank();
        f0            = bus.front;
        bus.clear_req = 1'b1;
        bus.clear_val = v;
        if (with_we) begin
            bus.we    = 1'b1;
            bus.wx    = 8'd0;
            bus.wy    = 8'd0;
            bus.wdata = 8'h5A;
            bus.wmask = 8'hFF;
        end
        tick();
        bus.clear_req = 1'b0;
        bus.we        = 1'b0;
        bus.clear_val = ~v;
        cnt  = 0;
        fchg = 1'b0;
        while (bus.busy === 1'b1 && cnt < DEPTH + 16) begin
            if (bus.front !== f0) fchg = 1'b1;
            bus.we        = (cnt == wr_at);
            bus.wx        = 8'd0;
            bus.wy        = 8'd0;
            bus.wdata     = 8'hFF;
            bus.wmask     = 8'hFF;
            bus.swap      = (cnt == swap_at);
            bus.clear_req = (cnt == 20);
            tick();
            cnt++;
        end
        bus.we        = 1'b0;
        bus.swap      = 1'b0;
        bus.clear_req = 1'b0;
        check("clear_busy_cycles", 32'(cnt), 32'(DEPTH));
        for (int a = 0; a < DEPTH; a++) mem[wb * DEPTH + a] = v;
        if (swap_at >= 0) begin
            check("swap_held_while_busy", 32'(fchg), 32'd0);
            check("swap_not_yet", 32'(bus.front), 32'(f0));
            tick();
            front_m = ~front_m;
            check("swap_after_busy", 32'(bus.front), 32'(front_m));
        end
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        n_checks      = 0;
        n_fail        = 0;
        front_m       = 1'b0;
        rst           = 1'b1;
        bus.we        = 1'b0;
        bus.wx        = 8'd0;
        bus.wy        = 8'd0;
        bus.wdata     = 8'd0;
        bus.wmask     = 8'd0;
        bus.re        = 1'b0;
        bus.rx        = 8'd0;
        bus.ry        = 8'd0;
        bus.clear_req = 1'b0;
        bus.clear_val = 8'd0;
        bus.swap      = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_rdata",  32'(bus.rdata),  32'd0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_front",  32'(bus.front),  32'd0);

        // First read: 1-cycle latency, single-cycle rvalid pulse
        bus.re = 1'b1;
        bus.rx = 8'd0;
        bus.ry = 8'd0;
        tick();
        bus.re = 1'b0;
        check("first_rvalid", 32'(bus.rvalid), 32'd1);
        check("first_busy",   32'(bus.busy),   32'd0);
        tick();
        check("rvalid_pulse", 32'(bus.rvalid), 32'd0);

        // Fill with A5 (both banks in the double-buffered build)
        do_clear(8'hA5, -1, 1'b0, -1);
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
        do_swap();
        do_clear(8'hA5, -1, 1'b0, -1);
`endif
        do_read(8, 3, "clr_a5_8_3");
        do_read(120, 63, "clr_a5_120_63");

        // Out-of-range reads return zero; out-of-range writes are dropped
        do_read(128, 0, "oor_rd_x");
        do_read(0, 64, "oor_rd_y");
        do_read(200, 200, "oor_rd_xy");
        do_write(128, 0, 8'h00, 8'hFF);
        do_write(0, 64, 8'h00, 8'hFF);
        tick();
        show_back();
        do_read(0, 1, "oor_wr_alias_x");
        do_read(0, 0, "oor_wr_alias_y");

        // Masked writes back to back on one byte: visibility and forwarding
        do_clear(8'h00, -1, 1'b0, -1);
        bus.we    = 1'b1;
        bus.wx    = 8'd16;
        bus.wy    = 8'd5;
        bus.wdata = 8'hFF;
        bus.wmask = 8'hF0;
        tick();
        bus.wdata = 8'h00;
        bus.wmask = 8'h30;
`ifndef FRAMEBUFFER_DOUBLE_BUFFER_EN
        bus.re = 1'b1;
        bus.rx = 8'd16;
        bus.ry = 8'd5;
`endif
        tick();
        bus.we = 1'b0;
        model_wr(16, 5, 8'hFF, 8'hF0);
        model_wr(16, 5, 8'h00, 8'h30);
`ifndef FRAMEBUFFER_DOUBLE_BUFFER_EN
        check("vis_rd_n_plus_1", 32'(bus.rdata), 32'h00);
        tick();
        check("vis_rd_n_plus_2", 32'(bus.rdata), 32'hF0);
        tick();
        bus.re = 1'b0;
        check("fwd_merge", 32'(bus.rdata), 32'hC0);
`else
        tick();
        do_read(16, 5, "back_write_old_front");
        do_swap();
        check("fwd_model", 32'(model_rd(16, 5)), 32'hC0);
        do_read(16, 5, "fwd_merge");
`endif

        // Write during a clear is dropped
        do_clear(8'h3E, 10, 1'b0, -1);
        show_back();
        do_read(0, 0, "drop_wr_busy");

        // Write together with clear_req is dropped; write in the first idle
        // cycle after the clear is accepted
        do_clear(8'h81, -1, 1'b1, -1);
        do_write(8, 0, 8'h77, 8'hFF);
        tick();
        show_back();
        do_read(0, 0, "drop_wr_with_clear");
        do_read(8, 0, "wr_first_idle_cycle");

        // Randomized concurrent writes and reads
        tick();
        prev_re = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (prev_re) begin
                check("rnd_rvalid", 32'(bus.rvalid), 32'd1);
                check("rnd_rdata",  32'(bus.rdata),  32'(prev_exp));
            end else begin
                check("rnd_rvalid_idle", 32'(bus.rvalid), 32'd0);
            end
            while (pq.size() > 0 && pq[0].t <= t - 2) begin
                pw = pq.pop_front();
                mem[pw.idx] = (mem[pw.idx] & ~pw.m) | (pw.d & pw.m);
            end
            wx_i = $urandom_range(0, 39);
            wy_i = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) wx_i = 128 + $urandom_range(0, 127);
            if ($urandom_range(0, 9) == 0) wy_i = 64 + $urandom_range(0, 191);
            wd = 8'($urandom);
            wm = 8'($urandom);
            bus.we    = ($urandom_range(0, 9) < 7);
            bus.wx    = 8'(wx_i);
            bus.wy    = 8'(wy_i);
            bus.wdata = wd;
            bus.wmask = wm;
            if (bus.we && in_rng(wx_i, wy_i)) begin
                pw.t   = t;
                pw.idx = idx_of(wbank(), wx_i, wy_i);
                pw.d   = wd;
                pw.m   = wm;
                pq.push_back(pw);
            end
            rx_i = $urandom_range(0, 39);
            ry_i = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) rx_i = 128 + $urandom_range(0, 127);
            bus.re   = $urandom_range(0, 1);
            bus.rx   = 8'(rx_i);
            bus.ry   = 8'(ry_i);
            prev_re  = bus.re;
            prev_exp = model_rd(rx_i, ry_i);
            tick();
        end
        bus.we = 1'b0;
        bus.re = 1'b0;
        if (prev_re) begin
            check("rnd_rvalid_last", 32'(bus.rvalid), 32'd1);
            check("rnd_rdata_last",  32'(bus.rdata),  32'(prev_exp));
        end
        tick();
        while (pq.size() > 0) begin
            pw = pq.pop_front();
            mem[pw.idx] = (mem[pw.idx] & ~pw.m) | (pw.d & pw.m);
        end
        show_back();
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 40; x += 8) begin
                do_read(x, y, "rnd_sweep");
            end
        end

`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
        // Write to back bank is invisible until swapped
        do_write(24, 7, 8'h3C, 8'hFF);
        tick();
        do_read(24, 7, "db_old_front");
        do_swap();
        do_read(24, 7, "db_swapped_3c");

        // Swap requested during a clear is applied after busy falls
        do_clear(8'h42, -1, 1'b0, 5);
        do_read(40, 9, "db_swap_after_clear");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
